audio_sample_fifo: RTL and testbench

Downstream stage of the I2S deserializer, clocked on the audio bit clock. It watches the left/right clock and the deserializer's parallel L/R outputs. Once per complete stereo frame it captures one {L,R} sample pair and pushes it into a small FIFO. The FIFO gives the controller side a valid/ready stream, so consumers no longer need to sample AUD_outL/AUD_outR directly or track LRCK themselves.

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_sync_fifo.sv | 59 +++++
 rtl/audio_sample_fifo.sv | 117 +++++++++++
 tb/tb_audio_sample_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and widths for the audio sample capture path.
package audio_pkg;

    localparam int AUD_SAMPLE_W = 16;
    localparam int DROP_CNT_W   = 8;

    typedef struct packed {
        logic [AUD_SAMPLE_W-1:0] left;
        logic [AUD_SAMPLE_W-1:0] right;
    } stereo_pair_t;

    localparam int PAIR_W = $bits(stereo_pair_t);

endpackage

// File: rtl/audio_sync_fifo.sv
// Generic single-clock FIFO with registered storage and wrap-bit pointers.
// A push while full is accepted only if a pop frees the head slot on the same edge.
module audio_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        level = wptr_q - rptr_q;
        rdata = mem_q[rptr_q[AW-1:0]];
    end

    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wptr_d  = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + (AW+1)'(1) : rptr_q;
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/audio_sample_fifo.sv
// Captures one {L,R} pair per LRCK frame from the I2S deserializer and
// presents it to the controller as a valid/ready stream through a small FIFO.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int DROP_FRAMES = 1
) (
    input  logic                      AUD_BCK,
    input  logic                      AUD_RST_N,
    input  logic                      AUD_LRCK,
    input  logic [AUD_SAMPLE_W-1:0]   AUD_inL,
    input  logic [AUD_SAMPLE_W-1:0]   AUD_inR,
    input  logic                      enable,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AUD_SAMPLE_W-1:0]   out_L,
    output logic [AUD_SAMPLE_W-1:0]   out_R,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [DROP_CNT_W-1:0]     drop_count
);

    localparam logic [3:0] SKIP_INIT = 4'(DROP_FRAMES);

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

    logic                  lr_prev_q, lr_prev_d;
    logic                  pending_q, pending_d;
    logic [3:0]            skip_cnt_q, skip_cnt_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

    logic         fall;
    logic         push_req;
    logic         pop_req;
    logic         push_lost;
    logic         fifo_full;
    logic         fifo_empty;
    stereo_pair_t wr_pair;
    stereo_pair_t rd_pair;

    // The deserializer updates its outputs on the fall edge, so the pair is
    // taken one edge later while pending is set.
    always_comb begin
        fall       = lr_prev_q & ~AUD_LRCK;
        lr_prev_d  = AUD_LRCK;
        pending_d  = pending_q;
        if (pending_q) begin
            pending_d = 1'b0;
        end
        if (fall) begin
            pending_d = 1'b1;
        end

        skip_cnt_d = skip_cnt_q;
        push_req   = 1'b0;
        if (pending_q) begin
            if (skip_cnt_q != 4'd0) begin
                skip_cnt_d = skip_cnt_q - 4'd1;
            end else begin
                push_req = enable;
            end
        end
    end

    always_comb begin
        pop_req      = ~fifo_empty & out_ready;
        push_lost    = push_req & fifo_full & ~pop_req;
        overflow_d   = overflow_q | push_lost;
        drop_count_d = push_lost ? sat_inc(drop_count_q) : drop_count_q;
        wr_pair.left  = AUD_inL;
        wr_pair.right = AUD_inR;
    end

    always_ff @(posedge AUD_BCK or negedge AUD_RST_N) begin
        if (!AUD_RST_N) begin
            lr_prev_q    <= 1'b0;
            pending_q    <= 1'b0;
            skip_cnt_q   <= SKIP_INIT;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            lr_prev_q    <= lr_prev_d;
            pending_q    <= pending_d;
            skip_cnt_q   <= skip_cnt_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    audio_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PAIR_W)
    ) u_fifo (
        .clk   (AUD_BCK),
        .rst_n (AUD_RST_N),
        .push  (push_req),
        .pop   (pop_req),
        .wdata (wr_pair),
        .rdata (rd_pair),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        out_valid  = ~fifo_empty;
        out_L      = rd_pair.left;
        out_R      = rd_pair.right;
        overflow   = overflow_q;
        drop_count = drop_count_q;
    end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Randomized bench for audio_sample_fifo against a queue-based frame model.
module tb_audio_sample_fifo;

    localparam int DEPTH       = 4;
    localparam int DROP_FRAMES = 1;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     lrck = 1'b1;
    logic [15:0]              in_l = '0;
    logic [15:0]              in_r = '0;
    logic                     enable = 1'b1;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [15:0]              out_l;
    logic [15:0]              out_r;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic [7:0]               drop_count;

    always #5 clk = ~clk;

    audio_sample_fifo #(
        .DEPTH       (DEPTH),
        .DROP_FRAMES (DROP_FRAMES)
    ) dut (
        .AUD_BCK    (clk),
        .AUD_RST_N  (rst_n),
        .AUD_LRCK   (lrck),
        .AUD_inL    (in_l),
        .AUD_inR    (in_r),
        .enable     (enable),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_L      (out_l),
        .out_R      (out_r),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Behavioural model: a queue of pairs plus frame bookkeeping.
    logic [31:0] mq[$];
    bit          m_lr_prev;
    bit          m_pend;
    int          m_skip;
    int          m_dcnt;
    bit          m_ovf;
    logic [15:0] cur_l = '0;
    logic [15:0] cur_r = '0;

    task automatic model_reset();
        mq.delete();
        m_lr_prev = 1'b0;
        m_pend    = 1'b0;
        m_skip    = DROP_FRAMES;
        m_dcnt    = 0;
        m_ovf     = 1'b0;
    endtask

    task automatic model_step();
        bit was_full;
        bit pop;
        bit push;
        was_full = (mq.size() == DEPTH);
        pop      = (mq.size() > 0) && out_ready;
        push     = 1'b0;
        if (m_pend) begin
            if (m_skip > 0) m_skip--;
            else if (enable) begin
                if (!was_full || pop) push = 1'b1;
                else begin
                    m_ovf = 1'b1;
                    if (m_dcnt < 255) m_dcnt++;
                end
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({in_l, in_r});
        m_pend    = m_lr_prev && !lrck;
        m_lr_prev = lrck;
    endtask

    task automatic sample();
        @(negedge clk);
        chk("valid", out_valid, mq.size() > 0);
        chk("level", level, mq.size());
        chk("ovf", overflow, m_ovf);
        chk("dcnt", drop_count, m_dcnt);
        if (mq.size() > 0) begin
            chk("out_l", out_l, mq[0][31:16]);
            chk("out_r", out_r, mq[0][15:0]);
        end
    endtask

    task automatic drive_edge(input logic lr, input logic en, input logic rdy);
        lrck      = lr;
        enable    = en;
        out_ready = rdy;
        in_l      = cur_l;
        in_r      = cur_r;
        @(posedge clk);
        model_step();
    endtask

    // One 32-cycle LRCK frame: high for 16, low for 16; new pair visible
    // from the edge after the fall. rmode: 0 never ready, 1 always,
    // 2 only on the capture edge, 3 random.
    task automatic run_frame(input bit en_f, input int rmode, input bit dir,
                             input logic [15:0] dl, input logic [15:0] dr, input bit lat);
        logic [15:0] nl;
        logic [15:0] nr;
        logic        rdy;
        nl = dir ? dl : 16'($urandom);
        nr = dir ? dr : 16'($urandom);
        for (int p = 0; p < 32; p++) begin
            sample();
            if (lat && p == 17) chk("lat_pre", out_valid, 1'b0);
            if (lat && p == 18) begin
                chk("lat_post", out_valid, 1'b1);
                chk("lat_l", out_l, nl);
                chk("lat_r", out_r, nr);
            end
            case (rmode)
                0:       rdy = 1'b0;
                1:       rdy = 1'b1;
                2:       rdy = (p == 17);
                default: rdy = ($urandom_range(0, 3) == 0);
            endcase
            if (p == 17) begin
                cur_l = nl;
                cur_r = nr;
            end
            drive_edge(p < 16, en_f, rdy);
        end
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_l", out_l, 16'h0);
        chk("rst_r", out_r, 16'h0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_dcnt", drop_count, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // First frame discarded, next two delivered 2 edges after the fall.
        run_frame(1'b1, 1, 1'b1, 16'h1111, 16'h2222, 1'b0);
        run_frame(1'b1, 1, 1'b1, 16'h2222, 16'h4444, 1'b1);
        run_frame(1'b1, 1, 1'b1, 16'h3333, 16'h6666, 1'b1);

        // Disabled frames: nothing captured, not counted as drops.
        run_frame(1'b0, 1, 1'b0, 16'h0, 16'h0, 1'b0);
        run_frame(1'b0, 1, 1'b0, 16'h0, 16'h0, 1'b0);
        sample();
        chk("en0_level", level, 0);
        chk("en0_dcnt", drop_count, 8'd0);
        run_frame(1'b1, 1, 1'b1, 16'hABCD, 16'h1234, 1'b1);

        // Fill past capacity with the consumer stalled.
        for (int f = 0; f < 6; f++) run_frame(1'b1, 0, 1'b0, 16'h0, 16'h0, 1'b0);
        sample();
        chk("full_level", level, 4);
        chk("full_ovf", overflow, 1'b1);
        chk("full_dcnt", drop_count, 8'd2);

        // Full FIFO, pop on the capture edge: push and pop both happen.
        run_frame(1'b1, 2, 1'b0, 16'h0, 16'h0, 1'b0);
        sample();
        chk("pp_level", level, 4);
        chk("pp_dcnt", drop_count, 8'd2);

        // Drain in order.
        run_frame(1'b0, 1, 1'b0, 16'h0, 16'h0, 1'b0);
        sample();
        chk("drain_level", level, 0);

        for (int f = 0; f < 24; f++) begin
            run_frame($urandom_range(0, 7) != 0, $urandom_range(0, 3), 1'b0, 16'h0, 16'h0, 1'b0);
        end

        // Drop counter saturation.
        for (int f = 0; f < 260; f++) run_frame(1'b1, 0, 1'b0, 16'h0, 16'h0, 1'b0);
        sample();
        chk("sat_dcnt", drop_count, 8'd255);
        chk("sat_ovf", overflow, 1'b1);

        // Reset with three pairs queued and a capture pending.
        run_frame(1'b0, 1, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int f = 0; f < 3; f++) run_frame(1'b1, 0, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int p = 0; p < 17; p++) begin
            sample();
            drive_edge(p < 16, 1'b1, 1'b0);
        end
        sample();
        chk("pre_rst_level", level, 3);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_ovf", overflow, 1'b0);
        chk("mid_rst_dcnt", drop_count, 8'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lrck  = 1'b0;
        for (int p = 18; p < 32; p++) begin
            sample();
            drive_edge(1'b0, 1'b1, 1'b1);
        end
        run_frame(1'b1, 1, 1'b1, 16'h5555, 16'h7777, 1'b0);
        sample();
        chk("post_rst_drop", level, 0);
        run_frame(1'b1, 1, 1'b1, 16'h6666, 16'h8888, 1'b1);
        sample();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
